// File: rtl/router_ctrl_wh.sv
// Five-port mesh switch controller: YX routing, per-output round-robin arbitration,
// wormhole output locking and credit-based flow control.
module router_ctrl_wh #(
   parameter int unsigned COORD_W = 4,
   parameter int unsigned CREDITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2*COORD_W-1:0]     local_addr_i,
   input  logic [5*2*COORD_W-1:0]   packet_addr_i,
   input  logic [4:0]               packet_valid_i,
   input  logic [4:0]               packet_tail_i,
   input  logic [4:0]               credit_return_i,
   output logic [24:0]              grant_o,
   output logic [4:0]               grant_v_o,
   output logic [4:0]               pop_o,
   output logic [4:0]               route_err_o,
   output logic [4:0]               credit_err_o
);

   localparam int unsigned CNT_W = $clog2(CREDITS + 1);
   localparam int unsigned AW    = 2 * COORD_W;
   localparam int unsigned NP    = 5;

   localparam logic [2:0] PortN = 3'd0;
   localparam logic [2:0] PortS = 3'd1;
   localparam logic [2:0] PortE = 3'd2;
   localparam logic [2:0] PortW = 3'd3;
   localparam logic [2:0] PortL = 3'd4;

   localparam logic [CNT_W-1:0] CredMax = CNT_W'(CREDITS);

   logic [NP-1:0]    lock_v_q, lock_v_d;
   logic [2:0]       lock_own_q [NP];
   logic [2:0]       lock_own_d [NP];
   logic [2:0]       rr_q [NP];
   logic [2:0]       rr_d [NP];
   logic [CNT_W-1:0] cred_q [NP];
   logic [CNT_W-1:0] cred_d [NP];
   logic [NP-1:0]    route_err_q, route_err_d;
   logic [NP-1:0]    credit_err_q, credit_err_d;

   logic [2:0]       req_out [NP];
   logic [NP-1:0]    req_v;
   logic [NP-1:0]    illegal;
   logic [NP-1:0]    elig [NP];
   logic [24:0]      grant;
   logic [NP-1:0]    row_v;

   logic [COORD_W-1:0] lx, ly;
   assign lx = local_addr_i[COORD_W +: COORD_W];
   assign ly = local_addr_i[0 +: COORD_W];

   // Bit o set when a head arriving on in_port may turn towards output o.
   function automatic logic [NP-1:0] legal_mask(input logic [2:0] in_port);
      case (in_port)
         PortN:   legal_mask = 5'b11110;
         PortS:   legal_mask = 5'b11101;
         PortE:   legal_mask = 5'b11000;
         PortW:   legal_mask = 5'b10100;
         PortL:   legal_mask = 5'b01111;
         default: legal_mask = 5'b00000;
      endcase
   endfunction

   // Per-input request: locked output for body flits, YX route for heads.
   always_comb begin
      logic [COORD_W-1:0] px, py;
      logic [2:0]         dir, own_out;
      logic               owned;
      logic [NP-1:0]      mask;
      for (int i = 0; i < NP; i++) begin
         px = packet_addr_i[i*AW+COORD_W +: COORD_W];
         py = packet_addr_i[i*AW +: COORD_W];
         if (py > ly)      dir = PortN;
         else if (py < ly) dir = PortS;
         else if (px > lx) dir = PortE;
         else if (px < lx) dir = PortW;
         else              dir = PortL;
         owned   = 1'b0;
         own_out = 3'd0;
         for (int o = 0; o < NP; o++) begin
            if (lock_v_q[o] && lock_own_q[o] == 3'(i)) begin
               owned   = 1'b1;
               own_out = 3'(o);
            end
         end
         mask       = legal_mask(3'(i));
         illegal[i] = !owned && !mask[dir];
         req_out[i] = owned ? own_out : dir;
         req_v[i]   = packet_valid_i[i] && !illegal[i];
      end
   end

   always_comb begin
      for (int o = 0; o < NP; o++) begin
         for (int i = 0; i < NP; i++) begin
            elig[o][i] = req_v[i] && (req_out[i] == 3'(o)) && (cred_q[o] != '0) &&
                         (!lock_v_q[o] || lock_own_q[o] == 3'(i));
         end
      end
   end

   // Round-robin search from rr_q; a locked output has only its owner eligible.
   always_comb begin
      logic found;
      int   c;
      grant = '0;
      for (int o = 0; o < NP; o++) begin
         found = 1'b0;
         for (int k = 0; k < NP; k++) begin
            c = int'(rr_q[o]) + k;
            if (c >= NP) c = c - NP;
            if (!found && elig[o][c]) begin
               grant[o*NP + c] = 1'b1;
               found           = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int o = 0; o < NP; o++) row_v[o] = |grant[o*NP +: NP];
   end

   always_comb begin
      grant_o   = rst ? grant : '0;
      grant_v_o = rst ? row_v : '0;
      pop_o     = '0;
      for (int o = 0; o < NP; o++) pop_o = pop_o | grant_o[o*NP +: NP];
   end

   assign route_err_o  = route_err_q;
   assign credit_err_o = credit_err_q;

   always_comb begin
      logic [2:0] gi;
      lock_v_d     = lock_v_q;
      route_err_d  = route_err_q | (packet_valid_i & illegal);
      credit_err_d = credit_err_q;
      for (int o = 0; o < NP; o++) begin
         lock_own_d[o] = lock_own_q[o];
         rr_d[o]       = rr_q[o];
         cred_d[o]     = cred_q[o];
         gi            = 3'd0;
         for (int i = 0; i < NP; i++) begin
            if (grant[o*NP + i]) gi = 3'(i);
         end
         if (credit_return_i[o] && cred_q[o] == CredMax) credit_err_d[o] = 1'b1;
         if (row_v[o] && !credit_return_i[o]) begin
            cred_d[o] = cred_q[o] - CNT_W'(1);
         end else if (!row_v[o] && credit_return_i[o] && cred_q[o] != CredMax) begin
            cred_d[o] = cred_q[o] + CNT_W'(1);
         end
         if (row_v[o]) begin
            if (packet_tail_i[gi]) begin
               lock_v_d[o] = 1'b0;
               rr_d[o]     = (gi == PortL) ? 3'd0 : gi + 3'd1;
            end else begin
               lock_v_d[o]   = 1'b1;
               lock_own_d[o] = gi;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lock_v_q     <= '0;
         route_err_q  <= '0;
         credit_err_q <= '0;
         for (int o = 0; o < NP; o++) begin
            lock_own_q[o] <= 3'd0;
            rr_q[o]       <= 3'd0;
            cred_q[o]     <= CredMax;
         end
      end else begin
         lock_v_q     <= lock_v_d;
         route_err_q  <= route_err_d;
         credit_err_q <= credit_err_d;
         for (int o = 0; o < NP; o++) begin
            lock_own_q[o] <= lock_own_d[o];
            rr_q[o]       <= rr_d[o];
            cred_q[o]     <= cred_d[o];
         end
      end
   end

endmodule

// File: tb/tb_router_ctrl_wh.sv
// Bench for router_ctrl_wh: directed scenarios plus random traffic, all checked every
// cycle against a behavioural model of locks, credits and round-robin priority.
module tb_router_ctrl_wh;

   localparam int NP = 5;
   localparam int CR = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  loc;
   logic [7:0]  addr [NP];
   logic [39:0] paddr;
   logic [4:0]  valid, tail, cret;
   logic [24:0] grant_o;
   logic [4:0]  grant_v_o, pop_o, route_err_o, credit_err_o;

   always #5 clk = ~clk;

   assign paddr = {addr[4], addr[3], addr[2], addr[1], addr[0]};

   router_ctrl_wh #(.COORD_W(4), .CREDITS(CR)) dut (
      .clk             (clk),
      .rst             (rst),
      .local_addr_i    (loc),
      .packet_addr_i   (paddr),
      .packet_valid_i  (valid),
      .packet_tail_i   (tail),
      .credit_return_i (cret),
      .grant_o         (grant_o),
      .grant_v_o       (grant_v_o),
      .pop_o           (pop_o),
      .route_err_o     (route_err_o),
      .credit_err_o    (credit_err_o)
   );

   int checks = 0;
   int failures = 0;

   // Model state: owner input of each output (-1 free), credits, rr pointer, sticky errors.
   int         m_own [NP];
   int         m_cred [NP];
   int         m_rr [NP];
   logic [4:0] m_rerr, m_cerr;
   logic [4:0] allowed [NP];
   logic [4:0] bad;
   logic [24:0] e_grant;
   logic [4:0]  e_gv, e_pop;
   logic [24:0] s_grant;
   logic [4:0]  s_gv, s_pop, s_rerr, s_cerr;

   task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < NP; o++) begin
         m_own[o]  = -1;
         m_cred[o] = CR;
         m_rr[o]   = 0;
      end
      m_rerr = '0;
      m_cerr = '0;
   endtask

   function automatic int yx_dir(input logic [7:0] a, input logic [7:0] l);
      if (a[3:0] > l[3:0]) return 0;
      if (a[3:0] < l[3:0]) return 1;
      if (a[7:4] > l[7:4]) return 2;
      if (a[7:4] < l[7:4]) return 3;
      return 4;
   endfunction

   task automatic model_comb();
      int tgt [NP];
      int best, bestd, d;
      e_grant = '0;
      bad     = '0;
      for (int i = 0; i < NP; i++) begin
         tgt[i] = -1;
         for (int o = 0; o < NP; o++) if (m_own[o] == i) tgt[i] = o;
         if (tgt[i] < 0) begin
            d = yx_dir(addr[i], loc);
            if (allowed[i][d]) tgt[i] = d;
            else if (valid[i]) bad[i] = 1'b1;
         end
         if (!valid[i]) tgt[i] = -1;
      end
      for (int o = 0; o < NP; o++) begin
         best  = -1;
         bestd = 99;
         if (m_cred[o] > 0) begin
            for (int i = 0; i < NP; i++) begin
               if (tgt[i] == o && (m_own[o] < 0 || m_own[o] == i) &&
                   ((i - m_rr[o] + NP) % NP) < bestd) begin
                  bestd = (i - m_rr[o] + NP) % NP;
                  best  = i;
               end
            end
         end
         if (best >= 0 && rst) e_grant[o*NP + best] = 1'b1;
      end
      e_gv  = '0;
      e_pop = '0;
      for (int o = 0; o < NP; o++) begin
         e_gv[o] = |e_grant[o*NP +: NP];
         e_pop   = e_pop | e_grant[o*NP +: NP];
      end
   endtask

   task automatic model_seq();
      int gi, nc;
      if (!rst) begin
         model_reset();
         return;
      end
      m_rerr = m_rerr | bad;
      for (int o = 0; o < NP; o++) begin
         gi = -1;
         for (int i = 0; i < NP; i++) if (e_grant[o*NP + i]) gi = i;
         if (cret[o] && m_cred[o] == CR) m_cerr[o] = 1'b1;
         nc = m_cred[o] + int'(cret[o]) - (gi >= 0 ? 1 : 0);
         m_cred[o] = (nc > CR) ? CR : nc;
         if (gi >= 0) begin
            if (tail[gi]) begin
               m_own[o] = -1;
               m_rr[o]  = (gi + 1) % NP;
            end else begin
               m_own[o] = gi;
            end
         end
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic run_cycle(input bit cmp);
      #1;
      model_comb();
      s_grant = grant_o;
      s_gv    = grant_v_o;
      s_pop   = pop_o;
      s_rerr  = route_err_o;
      s_cerr  = credit_err_o;
      if (cmp) begin
         chk("grant_o", s_grant, e_grant);
         chk("grant_v_o", {20'd0, s_gv}, {20'd0, e_gv});
         chk("pop_o", {20'd0, s_pop}, {20'd0, e_pop});
         chk("route_err_o", {20'd0, s_rerr}, {20'd0, m_rerr});
         chk("credit_err_o", {20'd0, s_cerr}, {20'd0, m_cerr});
      end
      @(posedge clk);
      model_seq();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      valid = '0;
      tail  = 5'b11111;
      cret  = '0;
      for (int i = 0; i < NP; i++) addr[i] = 8'h22;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      run_cycle(1);
      rst = 1'b1;
   endtask

   initial begin
      allowed[0] = 5'b11110;
      allowed[1] = 5'b11101;
      allowed[2] = 5'b11000;
      allowed[3] = 5'b10100;
      allowed[4] = 5'b01111;
      model_reset();
      loc = 8'h22;
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      run_cycle(0);
      run_cycle(1);
      rst = 1'b1;
      run_cycle(1);
      chk("reset_route_err", {20'd0, s_rerr}, 25'd0);
      chk("reset_credit_err", {20'd0, s_cerr}, 25'd0);

      // L -> N single flits exhaust N credits.
      valid = 5'b10000;
      addr[4] = 8'h24;
      run_cycle(1);
      chk("lit_l_to_n_grant", s_grant, 25'h0000010);
      chk("lit_l_to_n_pop", {20'd0, s_pop}, 25'h10);
      for (int k = 0; k < 3; k++) run_cycle(1);
      run_cycle(1);
      chk("lit_n_no_credit", {20'd0, s_gv}, 25'd0);
      do_reset();

      // N, S, L all to E: rotation starts at N.
      valid = 5'b10011;
      addr[0] = 8'h52; addr[1] = 8'h52; addr[4] = 8'h52;
      run_cycle(1);
      chk("lit_rr_first", s_grant, 25'd1 << 10);
      run_cycle(1);
      chk("lit_rr_second", s_grant, 25'd1 << 11);
      run_cycle(1);
      chk("lit_rr_third", s_grant, 25'd1 << 14);
      do_reset();

      // W 3-flit packet to L with N also targeting L and a bubble mid-packet.
      valid = 5'b01000; tail = 5'b10111;
      run_cycle(1);
      chk("lit_w_head", s_grant, 25'd1 << 23);
      valid = 5'b01001;
      run_cycle(1);
      chk("lit_w_body", s_grant, 25'd1 << 23);
      valid = 5'b00001;
      run_cycle(1);
      chk("lit_n_blocked", {20'd0, s_gv}, 25'd0);
      valid = 5'b01001; tail = 5'b11111;
      run_cycle(1);
      chk("lit_w_tail", s_grant, 25'd1 << 23);
      valid = 5'b00001;
      run_cycle(1);
      chk("lit_n_after_tail", s_grant, 25'd1 << 20);

      // E input needing N: illegal turn.
      valid = 5'b00100; addr[2] = 8'h25;
      run_cycle(1);
      chk("lit_illegal_pop", {20'd0, s_pop}, 25'd0);
      valid = 5'b00000;
      run_cycle(1);
      chk("lit_route_err", {20'd0, s_rerr}, 25'h04);
      run_cycle(1);
      chk("lit_route_err_sticky", {20'd0, s_rerr}, 25'h04);
      do_reset();

      // S output credit exhaustion, return, and overflow.
      valid = 5'b10000; addr[4] = 8'h20;
      for (int k = 0; k < 4; k++) run_cycle(1);
      cret = 5'b00010;
      run_cycle(1);
      chk("lit_s_zero_credit", {20'd0, s_gv}, 25'd0);
      run_cycle(1);
      chk("lit_s_grant_and_return", s_grant, 25'd1 << 9);
      cret = 5'b00000;
      run_cycle(1);
      chk("lit_s_last_credit", s_grant, 25'd1 << 9);
      valid = 5'b00000; cret = 5'b00010;
      for (int k = 0; k < 5; k++) run_cycle(1);
      cret = 5'b00000;
      run_cycle(1);
      chk("lit_credit_err", {20'd0, s_cerr}, 25'h02);

      // Reset mid-packet clears the W->L lock.
      do_reset();
      valid = 5'b01000; tail = 5'b10111; addr[3] = 8'h22;
      run_cycle(1);
      rst = 1'b0;
      run_cycle(1);
      rst = 1'b1;
      valid = 5'b01001; addr[0] = 8'h22;
      run_cycle(1);
      chk("lit_after_reset_n", s_grant, 25'd1 << 20);
      chk("lit_after_reset_err", {20'd0, s_cerr}, 25'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         if (n % 600 == 0) loc = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
         for (int i = 0; i < NP; i++) begin
            addr[i]  = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
            valid[i] = ($urandom_range(0, 3) != 0);
            tail[i]  = ($urandom_range(0, 2) == 0);
            cret[i]  = ($urandom_range(0, 3) == 0);
         end
         rst = ($urandom_range(0, 299) != 0);
         run_cycle(1);
      end
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
